operand_gather8: RTL and testbench
==================================

# operand_gather8

Upstream loader for the eight-operand bitwise reduction stage. Accepts `WIDTH`-bit words one at a time over a valid/ready stream and packs up to eight of them into a frame. Presents the frame on parallel ports `a`..`h`, held stable until the downstream stage accepts it. Unfilled slots are padded with all-ones, the identity for the downstream AND reduction, so short frames do not corrupt the result.

## Interface
- `WIDTH`, default 7: width of each operand word and each output port.
- `TIMEOUT`, default 16: idle cycles before a partial frame is closed. Used only when the timeout feature is compiled in.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the block can accept a word.
- `in_data`  in  WIDTH  operand word.
- `in_last`  in  1  the word is the final word of its frame; valid only with `in_valid`.
- `out_valid`  out  1  a frame is present on `a`..`h`.
- `out_ready`  in  1  the downstream stage accepts the frame.
- `a`, `b`, `c`, `d`, `e`, `f`, `g`, `h`  out  WIDTH each  slots 0..7.
- `out_count`  out  4  number of real (non-pad) words in the frame, 1..8.

## Operation
- Two states.
  - FILL: `in_ready=1`, `out_valid=0`.
  - HOLD: `in_ready=0`, `out_valid=1`.
- A word is accepted when `in_valid && in_ready`. It is written to slot[idx], and idx increments (3-bit).
- In FILL, the frame closes on any of these. Closing registers `out_count` and moves to HOLD.
  - An accepted word with idx==7.
  - An accepted word with `in_last=1`.
  - A timeout, when the feature is enabled.
- Slots beyond the last accepted word stay 7'h7F-style all-ones.
- In HOLD, `out_ready=1` completes the handshake. On that edge:
  - all slots reload to all-ones;
  - idx returns to 0;
  - `out_count` returns to 0;
  - state returns to FILL.
- `in_ready` is a decode of the state. There is no same-cycle pass-through, so a word cannot be accepted in the cycle a frame is released.
- `in_last` asserted together with idx==7 behaves the same as a normal eighth word.
- `in_valid` asserted during HOLD is ignored. The source must hold its word until `in_ready` is high.

## Timing
- Reset values:
  - state FILL; idx 0;
  - `out_valid=0`; `in_ready=1` once reset deasserts (0 while `rst` is high);
  - `a`..`h` all-ones; `out_count=0`; timeout counter 0.
- Latency: `out_valid` rises on the clock edge that accepts the closing word, so it is visible one cycle later.
- Throughput: at most one frame per N+1 cycles, where N is the number of words in the frame.
- `a`..`h` and `out_count` are registered. They are stable throughout HOLD.
- Reset mid-frame or mid-HOLD discards the partial or pending frame immediately, without waiting for a clock edge.

## Configuration
- Macro: `OPERAND_GATHER_TIMEOUT_EN`.
- Defined:
  - In FILL with idx>0, a counter increments on every cycle without an accept. It clears on every accept.
  - When the counter reaches `TIMEOUT-1`, the frame closes on that edge, exactly as if `in_last` had been seen. `out_count` equals idx.
  - In FILL with idx==0, the counter stays at 0.
- Undefined:
  - No counter logic is built, and `TIMEOUT` is ignored.
  - Frames close only on the eighth word or `in_last`.

## Structure
- Package `operand_gather_pkg` holds:
  - `NUM_SLOTS=8`;
  - `typedef enum logic {FILL, HOLD} gather_state_t`.
- Sub-module `operand_gather_timer`: the idle counter, with `clk`, `rst`, `clr`, `run` and a `expire` pulse output. It is instantiated only under `OPERAND_GATHER_TIMEOUT_EN`.

## Test plan
All scenarios use `WIDTH=7`.
- Full frame: words 7'h01..7'h08 sent back-to-back, `out_ready=1`.
  - `out_valid` is high for one cycle, in the cycle after the 8th accept.
  - `a..h` = 01..08; `out_count=8`.
  - `in_ready=0` in that cycle and high in the next.
- Short frame: 7'h7E, 7'h3F, 7'h7F with `in_last` on the third word.
  - `a=7E`, `b=3F`, `c..h=7F`; `out_count=3`.
  - The downstream AND of all slots is 7'h3E.
- Backpressure: a frame is completed, then `out_ready=0` for 5 cycles while `in_valid=1`.
  - `out_valid` is held and `a..h` stay unchanged.
  - No word is accepted.
  - After `out_ready=1`, the next frame starts from slot a.
- Reset: `rst` is pulsed after 4 accepted words.
  - Outputs show all-ones, `out_valid=0` and `out_count=0` without a clock edge.
  - The next 8 words form a clean frame.
- Timeout: `OPERAND_GATHER_TIMEOUT_EN` defined, `TIMEOUT=4`; 2 words sent, then idle.
  - `out_valid` rises after 4 idle cycles; `out_count=2`; `c..h=7F`.
  - With the macro undefined, there is no `out_valid` after 20 idle cycles.

Source files
------------

// File: rtl/operand_gather_pkg.sv
// rtl/operand_gather_pkg.sv - shared constants and state type for the operand gather loader
package operand_gather_pkg;

  localparam int NUM_SLOTS = 8;

  typedef enum logic {FILL, HOLD} gather_state_t;

endpackage

// File: rtl/operand_gather8_if.sv
// rtl/operand_gather8_if.sv - word stream in, eight-slot frame out
interface operand_gather8_if #(
  parameter int WIDTH = 7
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] h;
  logic [3:0]       out_count;

  // Word source and frame consumer side
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, a, b, c, d, e, f, g, h, out_count
  );

  // Gather block side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, a, b, c, d, e, f, g, h, out_count
  );
endinterface

// File: rtl/operand_gather_timer.sv
// rtl/operand_gather_timer.sv - idle counter that closes a stalled partial frame
module operand_gather_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // Expire on the edge where the TIMEOUT-th consecutive idle cycle completes
  assign expire = run && (count == CW'(TIMEOUT - 1));

  // Count idle cycles; restart on any accept or whenever not counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || expire) begin
      count <= '0;
    end else if (run) begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/operand_gather8.sv
// rtl/operand_gather8.sv - packs up to eight words into a padded frame; OPERAND_GATHER_TIMEOUT_EN adds idle close
module operand_gather8
  import operand_gather_pkg::*;
#(
  parameter int WIDTH   = 7,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  operand_gather8_if.slave bus
);
  gather_state_t    state;
  gather_state_t    state_next;
  logic [2:0]       idx;
  logic [3:0]       count;
  logic [WIDTH-1:0] slot [NUM_SLOTS];
  logic             ready;
  logic             accept;
  logic             close;
  logic             timeout_expire;

`ifdef OPERAND_GATHER_TIMEOUT_EN
  logic timer_run;
  logic timer_clr;

  // Only a partially filled frame with no word arriving counts as idle
  assign timer_run = (state == FILL) && (idx != 3'd0) && !accept;
  assign timer_clr = accept || (state != FILL) || (idx == 3'd0);

  operand_gather_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .run    (timer_run),
    .expire (timeout_expire)
  );
`else
  // TIMEOUT has no effect in this build; the compare is constant false
  assign timeout_expire = (TIMEOUT < 0);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Handshake decode and frame-close / release decisions
  always_comb begin
    state_next = state;
    close      = 1'b0;
    ready      = (state == FILL) && !rst;
    accept     = bus.in_valid && ready;
    case (state)
      FILL: begin
        if (accept && ((idx == 3'd7) || bus.in_last)) begin
          close = 1'b1;
        end
        if (timeout_expire) begin
          close = 1'b1;
        end
        if (close) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Slot storage, fill index and registered word count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot[i] <= '1;
      end
      idx   <= 3'd0;
      count <= 4'd0;
    end else if ((state == HOLD) && bus.out_ready) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot[i] <= '1;
      end
      idx   <= 3'd0;
      count <= 4'd0;
    end else if (accept) begin
      slot[idx] <= bus.in_data;
      idx       <= idx + 3'd1;
      if (close) begin
        count <= {1'b0, idx} + 4'd1;
      end
    end else if (close) begin
      count <= {1'b0, idx};
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_count = count;
  assign bus.a = slot[0];
  assign bus.b = slot[1];
  assign bus.c = slot[2];
  assign bus.d = slot[3];
  assign bus.e = slot[4];
  assign bus.f = slot[5];
  assign bus.g = slot[6];
  assign bus.h = slot[7];
endmodule

// File: tb/tb_operand_gather8.sv
// tb/tb_operand_gather8.sv - self-checking bench for operand_gather8; honours OPERAND_GATHER_TIMEOUT_EN
module tb_operand_gather8;
  localparam int TB_WIDTH   = 7;
  localparam int TB_TIMEOUT = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  operand_gather8_if #(.WIDTH(TB_WIDTH)) bus();

  operand_gather8 #(
    .WIDTH   (TB_WIDTH),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: list of words gathered so far, whether a frame is on offer, idle cycles
  logic [6:0] m_w [8];
  int         m_n;
  bit         m_hold;
  int         m_idle;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold = 0; m_n = 0; m_idle = 0;
      for (int i = 0; i < 8; i++) m_w[i] = 7'h7F;
    end else if (m_hold) begin
      if (bus.out_ready) begin
        m_hold = 0; m_n = 0; m_idle = 0;
        for (int i = 0; i < 8; i++) m_w[i] = 7'h7F;
      end
    end else if (bus.in_valid) begin
      m_w[m_n] = bus.in_data;
      m_n++;
      m_idle = 0;
      if (m_n == 8 || bus.in_last) m_hold = 1;
    end
`ifdef OPERAND_GATHER_TIMEOUT_EN
    else if (m_n > 0) begin
      m_idle++;
      if (m_idle == TB_TIMEOUT) begin
        m_hold = 1;
        m_idle = 0;
      end
    end
`endif
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [6:0] act [8];
    act = '{bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h};
    chk("model out_valid", 32'(bus.out_valid), 32'(m_hold));
    chk("model in_ready", 32'(bus.in_ready), 32'(!m_hold && !rst));
    chk("model out_count", 32'(bus.out_count), m_hold ? 32'(m_n) : 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("model slot%0d", i), 32'(act[i]), 32'(m_w[i]));
  end

  // Present one word and return at the negedge after it was accepted
  task automatic send(input logic [6:0] dat, input bit last);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = dat;
    bus.in_last  = last;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("send in_ready timeout", 32'(guard), 32'd0);
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    int n;
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    #1;
    chk("reset in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset a", 32'(bus.a), 32'h7F);
    chk("reset count", 32'(bus.out_count), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", 32'(bus.in_ready), 32'd1);

    // Full frame, back to back
    for (int i = 1; i <= 8; i++) send(7'(i), 1'b0);
    idle_in();
    chk("full out_valid", 32'(bus.out_valid), 32'd1);
    chk("full in_ready", 32'(bus.in_ready), 32'd0);
    chk("full a", 32'(bus.a), 32'h01);
    chk("full d", 32'(bus.d), 32'h04);
    chk("full h", 32'(bus.h), 32'h08);
    chk("full count", 32'(bus.out_count), 32'd8);
    @(negedge clk);
    chk("full released", 32'(bus.out_valid), 32'd0);
    chk("full ready again", 32'(bus.in_ready), 32'd1);

    // Short frame closed by in_last
    send(7'h7E, 1'b0); send(7'h3F, 1'b0); send(7'h7F, 1'b1);
    idle_in();
    chk("short a", 32'(bus.a), 32'h7E);
    chk("short b", 32'(bus.b), 32'h3F);
    chk("short c", 32'(bus.c), 32'h7F);
    chk("short h", 32'(bus.h), 32'h7F);
    chk("short count", 32'(bus.out_count), 32'd3);
    chk("short and", 32'(bus.a & bus.b & bus.c & bus.d & bus.e & bus.f & bus.g & bus.h), 32'h3E);
    @(negedge clk);

    // Backpressure with a word waiting
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(7'h10 + 7'(i), 1'b0);
    bus.in_data = 7'h55; bus.in_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp a", 32'(bus.a), 32'h10);
      chk("bp h", 32'(bus.h), 32'h17);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp released", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    idle_in();
    chk("bp next a", 32'(bus.a), 32'h55);
    chk("bp next b", 32'(bus.b), 32'h7F);
    send(7'h56, 1'b1);
    idle_in();
    chk("bp next count", 32'(bus.out_count), 32'd2);
    @(negedge clk);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 4; i++) send(7'h20 + 7'(i), 1'b0);
    idle_in();
    #2 rst = 1'b1;
    #1;
    chk("async rst a", 32'(bus.a), 32'h7F);
    chk("async rst b", 32'(bus.b), 32'h7F);
    chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("async rst count", 32'(bus.out_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) send(7'h30 + 7'(i), 1'b0);
    idle_in();
    chk("clean a", 32'(bus.a), 32'h30);
    chk("clean h", 32'(bus.h), 32'h37);
    chk("clean count", 32'(bus.out_count), 32'd8);
    @(negedge clk);

    // Idle behaviour after two words
    bus.out_ready = 1'b0;
    send(7'h40, 1'b0); send(7'h41, 1'b0);
    idle_in();
`ifdef OPERAND_GATHER_TIMEOUT_EN
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("timeout idle cycles", 32'(n), 32'd4);
    chk("timeout count", 32'(bus.out_count), 32'd2);
    chk("timeout b", 32'(bus.b), 32'h41);
    chk("timeout c", 32'(bus.c), 32'h7F);
    bus.out_ready = 1'b1;
    @(negedge clk);
`else
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    chk("no timeout out_valid", 32'(n), 32'd0);
    bus.out_ready = 1'b1;
    send(7'h42, 1'b1);
    idle_in();
    chk("closed count", 32'(bus.out_count), 32'd3);
    @(negedge clk);
`endif
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
